fwrisc_shadow_callstack: RTL and testbench

Parametrised shadow return-address stack that checks for call-stack corruption in the fwrisc core. It monitors decode-stage call, return, link-store and link-reload events. It keeps a DEPTH-entry circular stack of return addresses and flags any return target or reloaded link value that differs from the recorded one. It sits beside the decoder as a non-intrusive checker and never stalls the pipeline.

---
 rtl/fwrisc_callstack_pkg.sv | 53 +++++
 rtl/fwrisc_callstack_ram.sv | 76 +++++++
 rtl/fwrisc_shadow_callstack.sv | 148 ++++++++++++++
 tb/tb_fwrisc_shadow_callstack.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_callstack_pkg.sv
// Shared types and constants for the fwrisc shadow return-address stack.
// Latency: n/a (declarations only).
// Backpressure: n/a. Op encodings mirror the fwrisc decoder's op-type and mem-op tables.
package fwrisc_callstack_pkg;

  // Decoder op types (subset used by the checker)
  localparam logic [4:0] OP_TYPE_ARITH  = 5'd0;
  localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
  localparam logic [4:0] OP_TYPE_LDST   = 5'd2;
  localparam logic [4:0] OP_TYPE_JUMP   = 5'd3;

  // Memory sub-ops
  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LH  = 6'd1;
  localparam logic [5:0] OP_LW  = 6'd2;
  localparam logic [5:0] OP_LBU = 6'd3;
  localparam logic [5:0] OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;
  localparam logic [5:0] OP_SH  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;

  // Registers treated as link registers (ra and t0)
  localparam logic [5:0] LINK_X1 = 6'd1;
  localparam logic [5:0] LINK_X5 = 6'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    LOAD_WAIT = 2'd2
  } spill_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PUSH    = 2'd1,
    POP     = 2'd2,
    POPPUSH = 2'd3
  } jump_class_e;

  function automatic logic is_link(input logic [5:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  // Return-address-stack hint decoding for JAL/JALR
  function automatic jump_class_e classify(input logic [5:0] rd, input logic [5:0] rs1);
    jump_class_e c;
    c = NONE;
    if (is_link(rd) && (!is_link(rs1) || (rs1 == rd))) c = PUSH;
    else if (!is_link(rd) && is_link(rs1))             c = POP;
    else if (is_link(rd) && is_link(rs1))              c = POPPUSH;
    return c;
  endfunction

endpackage

// File: rtl/fwrisc_callstack_ram.sv
// Circular DEPTH-entry return-address store with write pointer, occupancy and per-entry spilled flag.
// Latency: writes land on the next clock; top-of-stack read is combinational from registers.
// Backpressure: none; a push while full overwrites the oldest entry.
module fwrisc_callstack_ram #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter bit SPILL_EN = 1'b0,
  localparam int PW      = $clog2(DEPTH),
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_replace,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_set_spill,
  output logic [XLEN-1:0] o_top_addr,
  output logic            o_top_spill,
  output logic [DW-1:0]   o_depth
);

  logic [XLEN-1:0] r_addr [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [DW-1:0]   r_depth;
  logic [PW-1:0]   w_top;

  // Power-of-two depth lets the pointer wrap for free
  assign w_top      = r_wp - PW'(1);
  assign o_top_addr = r_addr[w_top];
  assign o_depth    = r_depth;

  // Write pointer and occupancy; occupancy saturates at DEPTH
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wp    <= '0;
      r_depth <= '0;
    end else if (i_push) begin
      r_wp <= r_wp + PW'(1);
      if (r_depth != DW'(DEPTH)) r_depth <= r_depth + DW'(1);
    end else if (i_pop && (r_depth != '0)) begin
      r_wp    <= w_top;
      r_depth <= r_depth - DW'(1);
    end
  end

  // Address storage: push writes at the pointer, replace rewrites the top
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else if (i_push) begin
      r_addr[r_wp] <= i_wdata;
    end else if (i_replace) begin
      r_addr[w_top] <= i_wdata;
    end
  end

  generate
    if (SPILL_EN) begin : g_spill
      logic [DEPTH-1:0] r_spill;
      // Spilled flag: cleared on any fresh write, set when the link is stored to memory
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)       r_spill        <= '0;
        else if (i_push)      r_spill[r_wp]  <= 1'b0;
        else if (i_replace)   r_spill[w_top] <= 1'b0;
        else if (i_set_spill) r_spill[w_top] <= 1'b1;
      end
      assign o_top_spill = r_spill[w_top];
    end else begin : g_nospill
      logic w_unused_spill;
      assign w_unused_spill = i_set_spill;
      assign o_top_spill    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fwrisc_shadow_callstack.sv
// Shadow return-address stack: flags return targets / reloaded links that differ from the recorded call.
// Latency: all outputs registered; mismatch/underflow one cycle after the triggering event.
// Backpressure: none, non-intrusive monitor. FWRISC_SHADOW_STACK_LDCHECK_EN adds the link-spill reload check.
module fwrisc_shadow_callstack
  import fwrisc_callstack_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_decode_valid,
  input  logic [4:0]                 i_op_type,
  input  logic [5:0]                 i_op,
  input  logic [5:0]                 i_rs1,
  input  logic [5:0]                 i_rs2,
  input  logic [5:0]                 i_rd,
  input  logic [XLEN-1:0]            i_link_addr,
  input  logic [XLEN-1:0]            i_jump_target,
  input  logic                       i_ld_data_valid,
  input  logic [XLEN-1:0]            i_ld_data,
  output logic [XLEN-1:0]            o_exp_data,
  output logic                       o_exp_data_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_mismatch,
  output logic [XLEN-1:0]            o_mismatch_exp,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int DW = $clog2(DEPTH + 1);
`ifdef FWRISC_SHADOW_STACK_LDCHECK_EN
  localparam bit LDCHECK = 1'b1;
`else
  localparam bit LDCHECK = 1'b0;
`endif

  jump_class_e     w_jclass;
  logic            w_empty, w_full, w_is_ret;
  logic            w_push, w_pop, w_replace;
  logic            w_ret_mis, w_ld_mis, w_set_spill;
  logic [XLEN-1:0] w_top_addr;
  logic            w_top_spill;
  logic [DW-1:0]   w_depth;
  logic            r_mismatch, r_underflow, r_overflow;
  logic [XLEN-1:0] r_mismatch_exp;

  assign w_jclass  = (i_decode_valid && (i_op_type == OP_TYPE_JUMP)) ? classify(i_rd, i_rs1) : NONE;
  assign w_empty   = (w_depth == '0);
  assign w_full    = (w_depth == DW'(DEPTH));
  assign w_is_ret  = (w_jclass == POP) || (w_jclass == POPPUSH);
  // A pop-then-push on an empty stack has nothing to replace, so it records a fresh entry
  assign w_push    = (w_jclass == PUSH) || ((w_jclass == POPPUSH) && w_empty);
  assign w_pop     = (w_jclass == POP) && !w_empty;
  assign w_replace = (w_jclass == POPPUSH) && !w_empty;
  assign w_ret_mis = w_is_ret && !w_empty && (i_jump_target != w_top_addr);

  fwrisc_callstack_ram #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .SPILL_EN (LDCHECK)
  ) u_ram (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_replace   (w_replace),
    .i_wdata     (i_link_addr),
    .i_set_spill (w_set_spill),
    .o_top_addr  (w_top_addr),
    .o_top_spill (w_top_spill),
    .o_depth     (w_depth)
  );

`ifdef FWRISC_SHADOW_STACK_LDCHECK_EN
  spill_state_e r_state, w_state_nxt, w_state_ld;
  logic [5:0]   r_link, w_link_nxt;
  logic         w_is_sw, w_is_lw;

  assign w_is_sw = i_decode_valid && (i_op_type == OP_TYPE_LDST) && (i_op == OP_SW);
  assign w_is_lw = i_decode_valid && (i_op_type == OP_TYPE_LDST) && (i_op == OP_LW);

  // Spill FSM state and the link register that armed it
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_link  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_link  <= w_link_nxt;
    end
  end

  // Load compare resolves first against the pre-update top, then the decode event steers the FSM
  always_comb begin
    w_state_ld  = r_state;
    w_ld_mis    = 1'b0;
    w_set_spill = 1'b0;
    w_link_nxt  = r_link;
    if ((r_state == LOAD_WAIT) && i_ld_data_valid) begin
      w_state_ld = IDLE;
      w_ld_mis   = !w_empty && (i_ld_data != w_top_addr);
    end
    w_state_nxt = w_state_ld;
    if ((w_jclass == PUSH) || (w_jclass == POPPUSH)) begin
      // A new call abandons any pending spill tracking for the previous frame
      w_state_nxt = ARMED;
      w_link_nxt  = i_rd;
    end else if (w_jclass == POP) begin
      w_state_nxt = IDLE;
    end else if (w_is_sw && (w_state_ld == ARMED) && (i_rs2 == r_link)) begin
      w_set_spill = !w_empty;
      w_state_nxt = IDLE;
    end else if (w_is_lw && (w_state_ld == IDLE) && is_link(i_rd) && !w_empty && w_top_spill) begin
      w_state_nxt = LOAD_WAIT;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = &{1'b0, i_ld_data_valid, i_ld_data, i_op, i_rs2, w_top_spill};
  assign w_ld_mis    = 1'b0;
  assign w_set_spill = 1'b0;
`endif

  // Registered event outputs; the expected value is held until the next mismatch
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mismatch     <= 1'b0;
      r_mismatch_exp <= '0;
      r_underflow    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_mismatch  <= w_ret_mis | w_ld_mis;
      r_underflow <= w_is_ret && w_empty;
      if (w_ret_mis | w_ld_mis) r_mismatch_exp <= w_top_addr;
      if (w_push && w_full)     r_overflow     <= 1'b1;
    end
  end

  assign o_exp_data       = w_empty ? '0 : w_top_addr;
  assign o_exp_data_valid = !w_empty;
  assign o_depth          = w_depth;
  assign o_mismatch       = r_mismatch;
  assign o_mismatch_exp   = r_mismatch_exp;
  assign o_overflow       = r_overflow;
  assign o_underflow      = r_underflow;

endmodule

// File: tb/tb_fwrisc_shadow_callstack.sv
// Directed bench for the shadow call stack with a queue-based reference model.
// Latency: model outputs are valid one clock after each event, like the DUT.
// Backpressure: n/a.
module tb_fwrisc_shadow_callstack;
  import fwrisc_callstack_pkg::*;

  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_ARMED = 1, M_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [4:0]  op_type = '0;
  logic [5:0]  op = '0, rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] la = '0, jt = '0, ldd = '0;
  logic        ldv = 1'b0;

  logic [31:0] o_exp_data, o_mismatch_exp;
  logic        o_exp_data_valid, o_mismatch, o_overflow, o_underflow;
  logic [3:0]  o_depth;

  int n_vec = 0;
  int n_mis = 0;

  fwrisc_shadow_callstack #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_decode_valid   (dv),
    .i_op_type        (op_type),
    .i_op             (op),
    .i_rs1            (rs1),
    .i_rs2            (rs2),
    .i_rd             (rd),
    .i_link_addr      (la),
    .i_jump_target    (jt),
    .i_ld_data_valid  (ldv),
    .i_ld_data        (ldd),
    .o_exp_data       (o_exp_data),
    .o_exp_data_valid (o_exp_data_valid),
    .o_depth          (o_depth),
    .o_mismatch       (o_mismatch),
    .o_mismatch_exp   (o_mismatch_exp),
    .o_overflow       (o_overflow),
    .o_underflow      (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- reference model: a bounded list of recorded return addresses
  logic [31:0] qa[$];
  bit          qs[$];
  int          mst = M_IDLE;
  logic [5:0]  mlink = '0;
  logic [31:0] m_exp_data = '0, m_mismatch_exp = '0;
  logic        m_valid = 1'b0, m_mismatch = 1'b0, m_overflow = 1'b0, m_underflow = 1'b0;
  int          m_depth = 0;

  function automatic bit lnk(input logic [5:0] r);
    return (r == 6'd1) || (r == 6'd5);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] top;
    bit mis, uf, ovf_now, jmp, rdl, is_push, is_pop;
    if (!rst_n) begin
      qa.delete();
      qs.delete();
      mst = M_IDLE;
      mlink = '0;
      m_exp_data <= '0; m_mismatch_exp <= '0; m_valid <= 1'b0;
      m_mismatch <= 1'b0; m_overflow <= 1'b0; m_underflow <= 1'b0; m_depth <= 0;
    end else begin
      mis = 0; uf = 0; ovf_now = 0;
      top = (qa.size() != 0) ? qa[qa.size()-1] : 32'd0;
`ifdef FWRISC_SHADOW_STACK_LDCHECK_EN
      if (mst == M_WAIT && ldv) begin
        mst = M_IDLE;
        if (qa.size() != 0 && ldd != top) mis = 1;
      end
`endif
      if (dv) begin
        jmp = (op_type == OP_TYPE_JUMP);
        rdl = lnk(rd);
        // a link destination always records; a link source other than rd itself consumes
        is_push = jmp && rdl;
        is_pop  = jmp && lnk(rs1) && !(rdl && rs1 == rd);
        if (is_pop) begin
          if (qa.size() == 0) uf = 1;
          else begin
            if (jt != top) mis = 1;
            void'(qa.pop_back());
            void'(qs.pop_back());
          end
        end
        if (is_push) begin
          qa.push_back(la);
          qs.push_back(1'b0);
          if (qa.size() > DEPTH) begin
            void'(qa.pop_front());
            void'(qs.pop_front());
            ovf_now = 1;
          end
        end
`ifdef FWRISC_SHADOW_STACK_LDCHECK_EN
        if (is_push) begin
          mst = M_ARMED; mlink = rd;
        end else if (is_pop) begin
          mst = M_IDLE;
        end else if (op_type == OP_TYPE_LDST && op == OP_SW && mst == M_ARMED && rs2 == mlink) begin
          if (qs.size() != 0) qs[qs.size()-1] = 1'b1;
          mst = M_IDLE;
        end else if (op_type == OP_TYPE_LDST && op == OP_LW && mst == M_IDLE && rdl &&
                     qs.size() != 0 && qs[qs.size()-1]) begin
          mst = M_WAIT;
        end
`endif
      end
      m_mismatch  <= mis;
      m_underflow <= uf;
      if (mis) m_mismatch_exp <= top;
      if (ovf_now) m_overflow <= 1'b1;
      m_depth    <= qa.size();
      m_valid    <= (qa.size() != 0);
      m_exp_data <= (qa.size() != 0) ? qa[qa.size()-1] : 32'd0;
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    check("exp_data", o_exp_data, m_exp_data);
    check("exp_data_valid", o_exp_data_valid, m_valid);
    check("depth", o_depth, m_depth);
    check("mismatch", o_mismatch, m_mismatch);
    check("mismatch_exp", o_mismatch_exp, m_mismatch_exp);
    check("overflow", o_overflow, m_overflow);
    check("underflow", o_underflow, m_underflow);
  end

  // ---------------- stimulus helpers
  task automatic dec(input logic [4:0] t, input logic [5:0] o, input logic [5:0] d,
                     input logic [5:0] s1, input logic [5:0] s2,
                     input logic [31:0] a, input logic [31:0] j);
    dv = 1'b1; op_type = t; op = o; rd = d; rs1 = s1; rs2 = s2; la = a; jt = j;
    @(posedge clk); #1;
    dv = 1'b0; op_type = '0; op = '0; rd = '0; rs1 = '0; rs2 = '0; la = '0; jt = '0;
  endtask

  task automatic call(input logic [31:0] a);
    dec(OP_TYPE_JUMP, 6'd0, 6'd1, 6'd0, 6'd0, a, a + 32'h1000);
  endtask

  task automatic ret(input logic [31:0] j);
    dec(OP_TYPE_JUMP, 6'd0, 6'd0, 6'd1, 6'd0, 32'h0, j);
  endtask

  task automatic sw_link();
    dec(OP_TYPE_LDST, OP_SW, 6'd0, 6'd2, 6'd1, 32'h0, 32'h0);
  endtask

  task automatic lw_link();
    dec(OP_TYPE_LDST, OP_LW, 6'd1, 6'd2, 6'd0, 32'h0, 32'h0);
  endtask

  task automatic ld_ret(input logic [31:0] d);
    ldv = 1'b1; ldd = d;
    @(posedge clk); #1;
    ldv = 1'b0; ldd = '0;
  endtask

  // misc jump table: rd, rs1, link_addr, target
  logic [5:0]  t_rd  [5] = '{6'd1, 6'd0, 6'd5, 6'd0, 6'd2};
  logic [5:0]  t_rs1 [5] = '{6'd1, 6'd0, 6'd5, 6'd5, 6'd1};
  logic [31:0] t_la  [5] = '{32'h800, 32'h0, 32'h804, 32'h0, 32'h0};
  logic [31:0] t_jt  [5] = '{32'h0, 32'h0, 32'h0, 32'h804, 32'h999};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_depth", o_depth, 4'd0);
    check("rst_valid", o_exp_data_valid, 1'b0);
    check("rst_exp_data", o_exp_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // two nested calls unwound correctly
    call(32'h100);
    call(32'h200);
    check("nest_top", o_exp_data, 32'h200);
    check("nest_depth", o_depth, 4'd2);
    ret(32'h200);
    ret(32'h100);
    check("nest_clean", o_mismatch, 1'b0);
    check("nest_empty", o_depth, 4'd0);

    // wrong return target
    call(32'h100);
    ret(32'h104);
    check("badret_pulse", o_mismatch, 1'b1);
    check("badret_exp", o_mismatch_exp, 32'h100);
    @(posedge clk); #1;
    check("badret_oneshot", o_mismatch, 1'b0);
    check("badret_hold", o_mismatch_exp, 32'h100);

    // overflow: nine calls into eight entries
    for (int i = 1; i <= 9; i++) call(32'(i * 16));
    check("ovf_flag", o_overflow, 1'b1);
    check("ovf_depth", o_depth, 4'd8);
    check("ovf_top", o_exp_data, 32'h90);
    for (int i = 9; i >= 2; i--) ret(32'(i * 16));
    check("ovf_unwind_clean", o_mismatch, 1'b0);
    check("ovf_unwind_empty", o_depth, 4'd0);
    ret(32'h10);
    check("underflow_pulse", o_underflow, 1'b1);
    check("underflow_nomis", o_mismatch, 1'b0);

    // spilled link reloaded intact
    call(32'h300);
    sw_link();
    lw_link();
    ld_ret(32'h300);
    check("reload_ok", o_mismatch, 1'b0);
    // spilled link reloaded corrupted
    call(32'h300);
    sw_link();
    lw_link();
    ld_ret(32'h304);
`ifdef FWRISC_SHADOW_STACK_LDCHECK_EN
    check("reload_bad", o_mismatch, 1'b1);
    check("reload_bad_exp", o_mismatch_exp, 32'h300);
`else
    check("reload_ignored", o_mismatch, 1'b0);
    check("reload_ignored_exp", o_mismatch_exp, 32'h100);
`endif
    ret(32'h300);
    ret(32'h300);

    // pop-then-push (JALR rd=5, rs1=1)
    call(32'h400);
    dec(OP_TYPE_JUMP, 6'd0, 6'd5, 6'd1, 6'd0, 32'h500, 32'h400);
    check("poppush_clean", o_mismatch, 1'b0);
    check("popush_depth", o_depth, 4'd1);
    check("popush_top", o_exp_data, 32'h500);
    dec(OP_TYPE_JUMP, 6'd0, 6'd0, 6'd5, 6'd0, 32'h0, 32'h500);

    // load return and a call in the same cycle
    call(32'h600);
    sw_link();
    lw_link();
    ldv = 1'b1; ldd = 32'h600;
    dec(OP_TYPE_JUMP, 6'd0, 6'd1, 6'd0, 6'd0, 32'h700, 32'h0);
    ldv = 1'b0; ldd = '0;
    check("same_cycle_clean", o_mismatch, 1'b0);
    check("same_cycle_depth", o_depth, 4'd2);
    ret(32'h700);
    ret(32'h600);

    // assorted jump encodings back to back
    for (int i = 0; i < 5; i++)
      dec(OP_TYPE_JUMP, 6'd0, t_rd[i], t_rs1[i], 6'd0, t_la[i], t_jt[i]);
    check("table_last_mis", o_mismatch, 1'b1);
    check("table_last_exp", o_mismatch_exp, 32'h800);

    // reset while waiting for a reload with three frames live
    call(32'hA00);
    call(32'hB00);
    call(32'hC00);
    sw_link();
    lw_link();
    check("pre_rst_depth", o_depth, 4'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_depth", o_depth, 4'd0);
    check("arst_valid", o_exp_data_valid, 1'b0);
    check("arst_exp", o_exp_data, 32'h0);
    check("arst_mis_exp", o_mismatch_exp, 32'h0);
    check("arst_ovf", o_overflow, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ld_ret(32'hDEAD);
    check("post_rst_load", o_mismatch, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
